deframer: RTL and testbench
===========================

Name: deframer

Overview:
- Receive-side counterpart of the transmit framer. Accepts an AXI-Stream whose tlast marks fixed FRAME_SIZE-beat frames and locks onto the frame boundaries.
- Checks every frame length, forwards data with regenerated tlast, a start-of-frame flag and a per-frame error flag, and keeps statistics counters.
- Sits at the receive end of the frame link, ahead of DMA or packet consumers.

Parameters:
- FRAME_SIZE, 64, beats per frame; legal range is 1 or more.
- DATA_WIDTH, 32, tdata width in bits.
- CNT_WIDTH, 16, width of the statistics counters.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- s_axis_tdata  in  DATA_WIDTH  input data
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- s_axis_tlast  in  1  end-of-frame marker from the framer
- m_axis_tdata  out  DATA_WIDTH  output data
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- m_axis_tlast  out  1  regenerated end of frame
- m_axis_tuser  out  2  bit0 = start of frame; bit1 = frame error, valid on the tlast beat only
- clear_stats  in  1  synchronous clear of the counters and sticky flags
- locked  out  1  high while in the LOCKED state
- frame_count  out  CNT_WIDTH  good frames received
- err_count  out  CNT_WIDTH  bad frames received
- err_short_sticky  out  1  a short frame has been seen since the last clear
- err_long_sticky  out  1  a long frame has been seen since the last clear

Behaviour:
- Clock is clk. Reset is reset_n: synchronous, active-low.
- Reset values:
  - state = HUNT, idx = 0
  - m_axis_tvalid = 0; m_axis_tdata, tlast and tuser = 0
  - locked = 0
  - both counters = 0, both sticky flags = 0
- Accept means s_axis_tvalid and s_axis_tready are both high on a clock edge.
- idx is the beat index within the frame, $clog2(FRAME_SIZE) bits wide, with a minimum of 1 bit.

State HUNT:
- s_axis_tready = 1 unconditionally. All beats are discarded, downstream stalls have no effect, and nothing is forwarded.
- An accepted beat with tlast=1 moves the state to LOCKED and sets idx=0. That tlast beat itself is discarded.

State LOCKED:
- s_axis_tready = ready of the output register slice.
- Each accepted beat is forwarded with:
  - tuser[0] = (idx==0)
  - m_axis_tlast = 1 when the beat is at idx==FRAME_SIZE-1 or carries s_axis_tlast.
- On each accepted beat, exactly one of the following applies:
  - Good frame (idx==FRAME_SIZE-1 and tlast=1): tuser[1]=0, frame_count++, idx=0.
  - Short frame (tlast=1 and idx<FRAME_SIZE-1): tuser[1]=1, err_count++, err_short_sticky=1, idx=0. State stays LOCKED, realigned on this tlast.
  - Long frame (idx==FRAME_SIZE-1 and tlast=0): the beat is still forwarded with m_axis_tlast=1 and tuser[1]=1. err_count++, err_long_sticky=1, state goes to HUNT, idx=0.
  - Otherwise: idx++.
- FRAME_SIZE=1: every beat is both idx 0 and the last index. A beat with tlast=1 is good; a beat with tlast=0 is long.

Output register slice:
- Full-throughput skid buffer with 1-cycle latency.
- Sustains one beat per clock while m_axis_tready=1.
- s_axis_tready is driven from a register, with no combinational path from m_axis_tready.
- Beats already in the slice drain normally after a transition to HUNT.

Counters and flags:
- Both counters saturate at all-ones and do not wrap.
- clear_stats zeroes both counters and both sticky flags on the next edge. If it coincides with an increment or error event, the clear wins.
- locked is a registered output equal to (state==LOCKED).

Reset mid-frame:
- The slice is emptied, any in-flight beats are lost, and the state returns to HUNT.
- No partial frame is completed afterwards.

Decomposition:
- Shared package frame_pkg:
  - state enum {HUNT, LOCKED}
  - tuser bit indices TUSER_SOF=0 and TUSER_ERR=1
  - helper function for the idx width
- Sub-module axis_skid_buffer with parameter WIDTH: carries {tdata, tlast, tuser} and is reusable by other stream blocks.

Test Plan (all with FRAME_SIZE=4):
- Lock-on: send a 2-beat tail with tlast on beat 2, then 3 good 4-beat frames. Required: the tail is dropped; locked rises the cycle after tail tlast is accepted; 12 beats are output with tlast on beats 4, 8 and 12 and tuser[0] on beats 1, 5 and 9; frame_count=3; err_count=0.
- Short frame: while locked, send a frame with tlast on beat 2, then a good frame. Required: the output beat 2 has tlast=1 and tuser=2'b10; err_short_sticky=1; err_count=1; the next frame has sof on its first beat and frame_count increments.
- Long frame: send 6 beats with no tlast. Required: output beat 4 has tlast=1 and tuser[1]=1; locked drops; beats 5 and 6 are discarded; err_long_sticky=1; a later tlast relocks.
- Backpressure: toggle m_axis_tready with a pseudo-random 50% pattern over 20 frames. Required: no beat is lost or duplicated, data order is preserved, and s_axis_tready stays high in HUNT.
- Stats: hold clear_stats on the same cycle a good frame completes. Required: frame_count=0 afterwards. Force frame_count to all-ones, then send one more good frame. Required: the count stays at all-ones.
- Reset mid-frame: assert reset_n=0 for one cycle after beat 2 of a locked frame. Required: m_axis_tvalid=0 and locked=0 on the next cycle, counters=0, and beats are dropped until the next tlast.

Source files
------------

// File: rtl/frame_pkg.sv
// rtl/frame_pkg.sv - shared types and helpers for the frame link
package frame_pkg;

  // Receive alignment state: HUNT discards until a tlast, LOCKED forwards frames
  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Bit positions inside the 2-bit tuser sideband
  localparam int TUSER_SOF = 0;
  localparam int TUSER_ERR = 1;
  localparam int TUSER_W   = 2;

  // Beat index width; a one-beat frame still needs a 1-bit index register
  function automatic int idx_width(input int frame_size);
    return (frame_size <= 1) ? 1 : $clog2(frame_size);
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// rtl/axis_skid_buffer.sv - full-throughput two-entry register slice for a stream
module axis_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] s_tdata,
  input  logic             s_tvalid,
  output logic             s_tready,
  output logic [WIDTH-1:0] m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready
);

  logic [WIDTH-1:0] skid_data;
  logic             skid_valid;
  logic             take;
  logic             out_free;

  // s_tready is a flop, so upstream never sees a combinational path from m_tready
  assign take     = s_tvalid & s_tready;
  assign out_free = ~m_tvalid | m_tready;

  // Output register refills from the skid entry first, otherwise straight from the input
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      m_tdata    <= '0;
      m_tvalid   <= 1'b0;
      skid_data  <= '0;
      skid_valid <= 1'b0;
      s_tready   <= 1'b1;
    end else if (out_free) begin
      if (skid_valid) begin
        m_tdata    <= skid_data;
        m_tvalid   <= 1'b1;
        skid_valid <= 1'b0;
        s_tready   <= 1'b1;
      end else begin
        m_tvalid <= take;
        if (take) begin
          m_tdata <= s_tdata;
        end
      end
    end else if (take) begin
      skid_data  <= s_tdata;
      skid_valid <= 1'b1;
      s_tready   <= 1'b0;
    end
  end

endmodule

// File: rtl/deframer.sv
// rtl/deframer.sv - receive-side frame aligner, length checker and statistics
module deframer
  import frame_pkg::*;
#(
  parameter int FRAME_SIZE = 64,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [1:0]            m_axis_tuser,
  input  logic                  clear_stats,
  output logic                  locked,
  output logic [CNT_WIDTH-1:0]  frame_count,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic                  err_short_sticky,
  output logic                  err_long_sticky
);

  localparam int            IW       = idx_width(FRAME_SIZE);
  localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_SIZE - 1);
  localparam int            SW       = DATA_WIDTH + 1 + TUSER_W;

  state_t          state;
  state_t          state_next;
  logic [IW-1:0]   idx;
  logic [IW-1:0]   idx_next;

  logic            at_last;
  logic            accept;
  logic            ev_good;
  logic            ev_short;
  logic            ev_long;
  logic            out_tlast;
  logic [1:0]      out_tuser;

  logic            slice_valid;
  logic            slice_ready;
  logic [SW-1:0]   slice_in;
  logic [SW-1:0]   slice_out;

  // Next state, beat classification and upstream handshake for the aligner
  always_comb begin
    state_next    = state;
    idx_next      = idx;
    s_axis_tready = 1'b1;
    slice_valid   = 1'b0;
    accept        = 1'b0;
    ev_good       = 1'b0;
    ev_short      = 1'b0;
    ev_long       = 1'b0;
    at_last       = (idx == LAST_IDX);
    out_tlast     = at_last | s_axis_tlast;
    out_tuser     = '0;
    // A mismatch between the regenerated and received boundary is a framing error
    out_tuser[TUSER_SOF] = (idx == '0);
    out_tuser[TUSER_ERR] = (s_axis_tlast != at_last);

    case (state)
      HUNT: begin
        // Downstream is irrelevant here: everything is swallowed until a boundary
        s_axis_tready = 1'b1;
        accept        = s_axis_tvalid;
        if (accept && s_axis_tlast) begin
          state_next = LOCKED;
          idx_next   = '0;
        end
      end

      LOCKED: begin
        s_axis_tready = slice_ready;
        slice_valid   = s_axis_tvalid;
        accept        = s_axis_tvalid & slice_ready;
        if (accept) begin
          if (at_last && s_axis_tlast) begin
            ev_good  = 1'b1;
            idx_next = '0;
          end else if (s_axis_tlast) begin
            // Early tlast: keep lock but realign on this boundary
            ev_short = 1'b1;
            idx_next = '0;
          end else if (at_last) begin
            // Missing tlast: alignment is no longer trusted
            ev_long    = 1'b1;
            idx_next   = '0;
            state_next = HUNT;
          end else begin
            idx_next = idx + IW'(1);
          end
        end
      end

      default: begin
        state_next = HUNT;
        idx_next   = '0;
      end
    endcase
  end

  // Aligner state, beat index and registered lock indication
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= HUNT;
      idx    <= '0;
      locked <= 1'b0;
    end else begin
      state  <= state_next;
      idx    <= idx_next;
      locked <= (state_next == LOCKED);
    end
  end

  // Saturating statistics; a clear in the same cycle as an event takes priority
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      frame_count      <= '0;
      err_count        <= '0;
      err_short_sticky <= 1'b0;
      err_long_sticky  <= 1'b0;
    end else if (clear_stats) begin
      frame_count      <= '0;
      err_count        <= '0;
      err_short_sticky <= 1'b0;
      err_long_sticky  <= 1'b0;
    end else begin
      if (ev_good && (frame_count != '1)) begin
        frame_count <= frame_count + CNT_WIDTH'(1);
      end
      if ((ev_short || ev_long) && (err_count != '1)) begin
        err_count <= err_count + CNT_WIDTH'(1);
      end
      if (ev_short) begin
        err_short_sticky <= 1'b1;
      end
      if (ev_long) begin
        err_long_sticky <= 1'b1;
      end
    end
  end

  assign slice_in = {s_axis_tdata, out_tlast, out_tuser};

  axis_skid_buffer #(
    .WIDTH (SW)
  ) u_slice (
    .clk      (clk),
    .reset_n  (reset_n),
    .s_tdata  (slice_in),
    .s_tvalid (slice_valid),
    .s_tready (slice_ready),
    .m_tdata  (slice_out),
    .m_tvalid (m_axis_tvalid),
    .m_tready (m_axis_tready)
  );

  assign {m_axis_tdata, m_axis_tlast, m_axis_tuser} = slice_out;

endmodule

// File: tb/tb_deframer.sv
// tb/tb_deframer.sv - scoreboard bench for the deframer
module tb_deframer;

  localparam int FS   = 4;
  localparam int DW   = 32;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic [1:0]    m_axis_tuser;
  logic          clear_stats;
  logic          locked;
  logic [CW-1:0] frame_count;
  logic [CW-1:0] err_count;
  logic          err_short_sticky;
  logic          err_long_sticky;

  deframer #(.FRAME_SIZE(FS), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .s_axis_tdata     (s_axis_tdata),
    .s_axis_tvalid    (s_axis_tvalid),
    .s_axis_tready    (s_axis_tready),
    .s_axis_tlast     (s_axis_tlast),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tready    (m_axis_tready),
    .m_axis_tlast     (m_axis_tlast),
    .m_axis_tuser     (m_axis_tuser),
    .clear_stats      (clear_stats),
    .locked           (locked),
    .frame_count      (frame_count),
    .err_count        (err_count),
    .err_short_sticky (err_short_sticky),
    .err_long_sticky  (err_long_sticky)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected output beats: {tdata, tlast, tuser}
  logic [DW+2:0] sb_q[$];
  int            n_out = 0;
  int            rdy_mode = 0;  // 0 always ready, 1 random, 2 stalled

  // Reference model state
  bit m_locked = 0;
  int m_idx    = 0;
  int m_fc     = 0;
  int m_ec     = 0;
  bit m_ss     = 0;
  bit m_sl     = 0;
  int beat_no  = 0;

  // Drive downstream ready and check every beat that will transfer on the next edge
  always @(negedge clk) begin
    logic [DW+2:0] e;
    case (rdy_mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = 1'($urandom_range(0, 1));
      default: m_axis_tready = 1'b0;
    endcase
    if (m_axis_tvalid && m_axis_tready) begin
      n_out++;
      if (sb_q.size() == 0) begin
        check("unexpected_beat", m_axis_tdata, 64'hdead);
      end else begin
        e = sb_q.pop_front();
        check("out_data", m_axis_tdata, e[DW+2:3]);
        check("out_tlast", m_axis_tlast, e[2]);
        check("out_tuser", m_axis_tuser, e[1:0]);
      end
    end
  end

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic model_accept(input logic [DW-1:0] d, input bit last, input bit clr);
    bit at_last;
    bit err;
    if (clr) begin
      m_fc = 0; m_ec = 0; m_ss = 0; m_sl = 0;
    end
    if (!m_locked) begin
      if (last) begin
        m_locked = 1;
        m_idx    = 0;
      end
    end else begin
      at_last = (m_idx == FS - 1);
      err     = (last != at_last);
      sb_q.push_back({d, at_last | last, err, m_idx == 0});
      if (at_last && last) begin
        if (!clr) m_fc = sat(m_fc);
        m_idx = 0;
      end else if (last) begin
        if (!clr) begin m_ec = sat(m_ec); m_ss = 1; end
        m_idx = 0;
      end else if (at_last) begin
        if (!clr) begin m_ec = sat(m_ec); m_sl = 1; end
        m_locked = 0;
        m_idx    = 0;
      end else begin
        m_idx++;
      end
    end
  endtask

  task automatic send_beat(input bit last, input bit clr = 0);
    logic [DW-1:0] d;
    bit rdy;
    int waited;
    d = 32'hA500_0000 + DW'(beat_no);
    beat_no++;
    @(negedge clk);
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    clear_stats   = clr;
    waited        = 0;
    forever begin
      rdy = s_axis_tready;
      if (!m_locked) check("hunt_ready", rdy, 1'b1);
      @(posedge clk);
      if (rdy) break;
      waited++;
      if (waited > 1000) begin
        check("ready_timeout", waited, 0);
        return;
      end
      @(negedge clk);
    end
    model_accept(d, last, clr);
  endtask

  task automatic gap();
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    clear_stats   = 1'b0;
  endtask

  task automatic send_frame(input int len, input bit with_last);
    for (int i = 0; i < len; i++) send_beat(with_last && (i == len - 1));
  endtask

  task automatic drain();
    int n = 0;
    gap();
    while ((sb_q.size() != 0 || m_axis_tvalid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain_left", sb_q.size(), 0);
  endtask

  task automatic check_stats(input string tag);
    check({tag, "_frames"}, frame_count, m_fc);
    check({tag, "_errs"}, err_count, m_ec);
    check({tag, "_short"}, err_short_sticky, m_ss);
    check({tag, "_long"}, err_long_sticky, m_sl);
    check({tag, "_locked"}, locked, m_locked);
  endtask

  initial begin
    reset_n       = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    clear_stats   = 1'b0;
    m_axis_tready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tvalid", m_axis_tvalid, 1'b0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_tready", s_axis_tready, 1'b1);
    reset_n = 1'b1;
    @(negedge clk);
    check_stats("rst");

    // Lock-on: 2-beat tail then three good frames
    send_beat(0);
    gap();
    check("tail1_locked", locked, 1'b0);
    send_beat(1);
    gap();
    check("tail2_locked", locked, 1'b1);
    n_out = 0;
    repeat (3) send_frame(FS, 1);
    drain();
    check("lock_nout", n_out, 12);
    check("lock_frames", frame_count, 3);
    check_stats("lock");

    // Short frame then a good frame
    send_frame(2, 1);
    send_frame(FS, 1);
    drain();
    check("short_sticky", err_short_sticky, 1'b1);
    check("short_errs", err_count, 1);
    check_stats("short");

    // Long frame: six beats without tlast, then relock
    for (int i = 0; i < FS; i++) send_beat(0);
    gap();
    check("long_locked", locked, 1'b0);
    send_beat(0);
    send_beat(0);
    drain();
    check("long_sticky", err_long_sticky, 1'b1);
    check_stats("long");
    rdy_mode = 2;
    send_beat(1);
    gap();
    check("relock", locked, 1'b1);
    rdy_mode = 0;
    send_frame(FS, 1);
    drain();
    check_stats("relock");

    // Backpressure over 20 frames
    rdy_mode = 1;
    repeat (20) send_frame(FS, 1);
    drain();
    rdy_mode = 0;
    check_stats("bp");

    // Clear coinciding with a completing good frame, then saturation
    send_beat(0); send_beat(0); send_beat(0);
    send_beat(1, 1);
    gap();
    check("clr_frames", frame_count, 0);
    check_stats("clr");
    repeat (CMAX) send_frame(FS, 1);
    drain();
    check("sat_full", frame_count, CMAX);
    send_frame(FS, 1);
    drain();
    check("sat_hold", frame_count, CMAX);
    check_stats("sat");

    // Reset after beat 2 of a locked frame with the output stalled
    rdy_mode = 2;
    send_beat(0);
    send_beat(0);
    gap();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("mid_rst_tvalid", m_axis_tvalid, 1'b0);
    check("mid_rst_locked", locked, 1'b0);
    sb_q.delete();
    m_locked = 0; m_idx = 0; m_fc = 0; m_ec = 0; m_ss = 0; m_sl = 0;
    check_stats("mid_rst");
    send_beat(0);
    send_beat(0);
    gap();
    check("mid_rst_hunt", locked, 1'b0);
    rdy_mode = 0;
    send_beat(1);
    send_frame(FS, 1);
    drain();
    check("mid_rst_frames", frame_count, 1);
    check_stats("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time limit so the run always terminates
  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
